// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - FIFO read port and output stream bundle for fifo_rd_stream_adapter
interface fifo_rd_stream_adapter_if #(
    parameter int DWIDTH = 1
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_re;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;

    modport master (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_re, out_valid, out_data
    );

    modport slave (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_re, out_valid, out_data
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read-side adapter to a valid/ready stream via a credit-controlled skid buffer
module fifo_rd_stream_adapter #(
    parameter int DWIDTH    = 1,
    parameter int DOREG     = 1,
    parameter int BUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    output logic [$clog2(BUF_DEPTH):0]   occupancy,
    fifo_rd_stream_adapter_if.master     bus
);
    localparam int PW = $clog2(BUF_DEPTH);

    if (DOREG < 0 || DOREG > 1 || BUF_DEPTH < DOREG + 2 ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_param
        $error("fifo_rd_stream_adapter: illegal DOREG/BUF_DEPTH combination");
    end

    logic [DWIDTH-1:0] buf_q [BUF_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       occ_q, inflight, credit;
    logic              re, cap, xfer;

    // Credit counts reads still in the pipe so a full buffer can never be overrun.
    assign credit = occ_q + inflight;
    assign re     = rst & ~bus.fifo_empty & ~flush & (credit < (PW+1)'(BUF_DEPTH));
    assign xfer   = bus.out_valid & bus.out_ready;

    assign bus.fifo_re   = re;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = buf_q[rd_ptr];
    assign occupancy     = occ_q;

    if (DOREG == 0) begin : g_nopipe
        assign cap      = re;
        assign inflight = '0;
    end else begin : g_pipe
        logic [DOREG-1:0] pipe_v, pipe_x;
        logic [DOREG:0]   sh_v, sh_x;

        assign sh_v = {pipe_v, re};
        assign sh_x = {pipe_x, 1'b0};
        assign cap  = sh_v[DOREG] & ~sh_x[DOREG] & ~flush;

        always_comb begin
            inflight = '0;
            for (int i = 0; i < DOREG; i++)
                inflight = inflight + (PW+1)'(pipe_v[i] & ~pipe_x[i]);
        end

        // Flush tags every in-flight read so its data is dropped when it lands.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pipe_v <= '0;
                pipe_x <= '0;
            end else begin
                pipe_v <= sh_v[DOREG-1:0];
                pipe_x <= flush ? sh_v[DOREG-1:0] : sh_x[DOREG-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            occ_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (cap)
                wr_ptr <= wr_ptr + PW'(1);
            if (xfer)
                rd_ptr <= rd_ptr + PW'(1);
            occ_q <= occ_q + (PW+1)'(cap) - (PW+1)'(xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (cap)
            buf_q[wr_ptr] <= bus.fifo_dout;
    end

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(bus.fifo_re && bus.fifo_empty));
    a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
        occ_q <= (PW+1)'(BUF_DEPTH));
    a_no_overrun: assert property (@(posedge clk) disable iff (!rst)
        !(cap && occ_q == (PW+1)'(BUF_DEPTH) && !xfer));
    a_data_stable: assert property (@(posedge clk) disable iff (!rst)
        (bus.out_valid && !bus.out_ready && !flush) |=> $stable(bus.out_data));
`endif
endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// tb/tb_fifo_rd_stream_adapter.sv - scoreboard bench for fifo_rd_stream_adapter (DOREG=1/depth 4 and DOREG=0/depth 2)
`timescale 1ns/1ps
module tb_fifo_rd_stream_adapter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, frst_n, flush_a, flush_b, gate;
    logic [2:0] occ_a;
    logic [1:0] occ_b;

    fifo_rd_stream_adapter_if #(.DWIDTH(8)) ifa ();
    fifo_rd_stream_adapter_if #(.DWIDTH(8)) ifb ();

    fifo_rd_stream_adapter #(.DWIDTH(8), .DOREG(1), .BUF_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .occupancy(occ_a), .bus(ifa));
    fifo_rd_stream_adapter #(.DWIDTH(8), .DOREG(0), .BUF_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .occupancy(occ_b), .bus(ifb));

    // FIFO models: A has a registered read port, B a combinational one.
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    int wr_a = 0, rd_a, wr_b = 0, rd_b;

    assign ifa.fifo_empty = (rd_a == wr_a) | gate;
    always @(posedge clk or negedge frst_n) begin
        if (!frst_n) rd_a <= wr_a;
        else if (ifa.fifo_re) begin
            ifa.fifo_dout <= mem_a[rd_a];
            rd_a <= rd_a + 1;
        end
    end

    assign ifb.fifo_empty = (rd_b == wr_b);
    assign ifb.fifo_dout  = mem_b[rd_b];
    always @(posedge clk or negedge frst_n) begin
        if (!frst_n) rd_b <= wr_b;
        else if (ifb.fifo_re) rd_b <= rd_b + 1;
    end

    logic [7:0] expa [$];
    logic [7:0] expb [$];
    int n_cmp = 0, n_bad = 0;
    int n, k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [7:0] v, input bit keep);
        mem_a[wr_a] = v;
        wr_a++;
        if (keep) expa.push_back(v);
    endtask

    task automatic push_b(input logic [7:0] v);
        mem_b[wr_b] = v;
        wr_b++;
        expb.push_back(v);
    endtask

    task automatic drain(input bit which);
        for (int i = 0; i < 200 && (which ? expb.size() : expa.size()) != 0; i++)
            @(negedge clk);
        if (which) check("b_drain_left", expb.size(), 0);
        else       check("a_drain_left", expa.size(), 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            if (expa.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_extra_word: got %0d expected none", ifa.out_data);
            end else check("a_word", 32'(ifa.out_data), 32'(expa.pop_front()));
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst === 1'b1 && ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
            if (expb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_extra_word: got %0d expected none", ifb.out_data);
            end else check("b_word", 32'(ifb.out_data), 32'(expb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; frst_n = 1'b0; flush_a = 1'b0; flush_b = 1'b0; gate = 1'b0;
        ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        frst_n = 1'b1;

        // 1: preload 0..7, full throughput
        for (int i = 0; i < 8; i++) push_a(8'(i), 1'b1);
        ifa.out_ready = 1'b1;
        #1;
        check("rst_a_re", 32'(ifa.fifo_re), 0);
        check("rst_a_valid", 32'(ifa.out_valid), 0);
        check("rst_a_occ", 32'(occ_a), 0);
        check("rst_b_valid", 32'(ifb.out_valid), 0);
        check("rst_b_occ", 32'(occ_b), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("t1_re", 32'(ifa.fifo_re), 32'(c < 8));
            check("t1_valid", 32'(ifa.out_valid), 32'(c >= 2 && c < 10));
            @(negedge clk);
        end

        // 2: backpressure fills exactly BUF_DEPTH, then drains without gaps
        ifa.out_ready = 1'b0;
        for (int i = 20; i < 28; i++) push_a(8'(i), 1'b1);
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ifa.fifo_re) n++;
            @(negedge clk);
        end
        #1;
        check("t2_reads", n, 4);
        check("t2_occ", 32'(occ_a), 4);
        check("t2_valid", 32'(ifa.out_valid), 1);
        check("t2_head", 32'(ifa.out_data), 20);
        @(negedge clk);
        ifa.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t2_nogap_valid", 32'(ifa.out_valid), 32'(c < 8));
            @(negedge clk);
        end

        // 3: flush with occupancy 2 and word 12 in flight
        ifa.out_ready = 1'b0;
        push_a(8'd10, 1'b0); push_a(8'd11, 1'b0); push_a(8'd12, 1'b0);
        k = 0;
        #1;
        while (occ_a != 3'd2 && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("t3_occ_before", 32'(occ_a), 2);
        flush_a = 1'b1;
        #1;
        check("t3_flush_re", 32'(ifa.fifo_re), 0);
        @(negedge clk);
        flush_a = 1'b0;
        #1;
        check("t3_valid_after", 32'(ifa.out_valid), 0);
        check("t3_occ_after", 32'(occ_a), 0);
        @(negedge clk); #1;
        check("t3_occ_later", 32'(occ_a), 0);
        ifa.out_ready = 1'b1;
        push_a(8'd13, 1'b1); push_a(8'd14, 1'b1);
        drain(1'b0);

        // 4: fifo_empty toggling every cycle
        @(negedge clk);
        for (int i = 30; i < 36; i++) push_a(8'(i), 1'b1);
        n = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            check("t4_re_while_empty", 32'(ifa.fifo_re & ifa.fifo_empty), 0);
            if (ifa.fifo_re) n++;
            @(negedge clk);
            gate = ~gate;
        end
        gate = 1'b0;
        check("t4_reads", n, 6);
        drain(1'b0);

        // 5: async reset mid-stream; 40 and 41 transfer before it
        @(negedge clk);
        for (int i = 40; i < 48; i++) push_a(8'(i), i < 42);
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b0; frst_n = 1'b0;
        #1;
        check("t5_valid_in_rst", 32'(ifa.out_valid), 0);
        check("t5_re_in_rst", 32'(ifa.fifo_re), 0);
        check("t5_occ_in_rst", 32'(occ_a), 0);
        @(negedge clk);
        rst = 1'b1; frst_n = 1'b1;
        push_a(8'd50, 1'b1); push_a(8'd51, 1'b1); push_a(8'd52, 1'b1);
        drain(1'b0);

        // 6: DOREG=0, depth 2, random then steady out_ready
        @(negedge clk);
        for (int i = 60; i < 76; i++) push_b(8'(i));
        for (k = 0; k < 400 && expb.size() != 0; k++) begin
            ifb.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("t6_random_left", expb.size(), 0);
        ifb.out_ready = 1'b1;
        for (int i = 80; i < 88; i++) push_b(8'(i));
        for (int c = 0; c < 11; c++) begin
            #1;
            check("t6_re", 32'(ifb.fifo_re), 32'(c < 8));
            check("t6_valid", 32'(ifb.out_valid), 32'(c >= 1 && c <= 8));
            @(negedge clk);
        end
        drain(1'b1);
        drain(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
